clk_div_sched: RTL and testbench



---
 rtl/clkgen_pkg.sv | 21 ++
 rtl/clk_div_core.sv | 69 ++++++
 rtl/clk_div_sched.sv | 148 ++++++++++++++
 tb/tb_clk_div_sched.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clkgen_pkg.sv
// ============================================================================
// Module      : clkgen_pkg
// Description : Shared state encoding and defaults for the tick/clock-enable
//               generator and its sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package clkgen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    localparam int CLKGEN_DEFAULT_DIV = 5;

endpackage : clkgen_pkg

`default_nettype wire

// File: rtl/clk_div_core.sv
// ============================================================================
// Module      : clk_div_core
// Description : Divide-by-N counter with wrap detect and registered tick and
//               clk_out. Holds the active divisor and exposes load/clear inputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_div_core #(
    parameter int NBITS       = 16,
    parameter int DEFAULT_DIV = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [NBITS-1:0] load_div_i,
    output logic             wrap_o,
    output logic             tick_o,
    output logic             clk_out_o
);

    logic [NBITS-1:0] cnt_q, cnt_d;
    logic [NBITS-1:0] div_q, div_d;
    logic             tick_q, tick_d;
    logic             clk_out_q, clk_out_d;

    // div_q is never zero, so div_q - 1 cannot underflow.
    assign wrap_o    = en_i && (cnt_q == (div_q - NBITS'(1)));
    assign tick_o    = tick_q;
    assign clk_out_o = clk_out_q;

    always_comb begin
        div_d     = div_q;
        cnt_d     = cnt_q;
        tick_d    = 1'b0;
        clk_out_d = clk_out_q;
        if (load_i) begin
            div_d = (load_div_i == '0) ? NBITS'(1) : load_div_i;
        end
        if (clear_i || !en_i) begin
            cnt_d = '0;
        end else if (wrap_o) begin
            cnt_d     = '0;
            tick_d    = 1'b1;
            clk_out_d = ~clk_out_q;
        end else begin
            cnt_d = cnt_q + NBITS'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            div_q     <= NBITS'(DEFAULT_DIV);
            tick_q    <= 1'b0;
            clk_out_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            tick_q    <= tick_d;
            clk_out_q <= clk_out_d;
        end
    end

endmodule : clk_div_core

`default_nettype wire

// File: rtl/clk_div_sched.sv
// ============================================================================
// Module      : clk_div_sched
// Description : Start/stop sequencer with one-shot/periodic modes and
//               period-aligned divisor reconfiguration over valid/ready.
//               Optional tick counter output enabled by CLKGEN_TICK_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_div_sched
    import clkgen_pkg::*;
#(
    parameter int NBITS       = 16,
    parameter int DEFAULT_DIV = CLKGEN_DEFAULT_DIV
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             cfg_valid,
    input  logic [NBITS-1:0] cfg_div,
    input  logic             cfg_oneshot,
    output logic             cfg_ready,
    output logic             tick,
    output logic             clk_out,
    output logic             busy,
`ifdef CLKGEN_TICK_CNT_EN
    output logic             done,
    output logic [NBITS-1:0] tick_cnt
`else
    output logic             done
`endif
);

    state_t           state_q;
    logic             oneshot_q;
    logic [NBITS-1:0] shadow_div_q;
    logic             shadow_os_q;
    logic             done_q;

    logic             w_xfer;
    logic             w_wrap;
    logic             w_load;
    logic [NBITS-1:0] w_load_div;
    logic             w_load_os;

    assign cfg_ready = (state_q != PEND);
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign w_xfer    = cfg_valid && cfg_ready;

    // A config lands in the active registers only on a period boundary:
    // immediately when idle, at a wrap, or when stop ends the run.
    always_comb begin
        w_load     = 1'b0;
        w_load_div = cfg_div;
        w_load_os  = cfg_oneshot;
        if (state_q == PEND && (stop || w_wrap)) begin
            w_load     = 1'b1;
            w_load_div = shadow_div_q;
            w_load_os  = shadow_os_q;
        end else if (w_xfer && (stop || state_q == IDLE || w_wrap)) begin
            w_load = 1'b1;
        end
    end

    clk_div_core #(
        .NBITS       (NBITS),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_core (
        .clk        (clk),
        .reset      (reset),
        .en_i       (state_q != IDLE),
        .clear_i    (stop),
        .load_i     (w_load),
        .load_div_i (w_load_div),
        .wrap_o     (w_wrap),
        .tick_o     (tick),
        .clk_out_o  (clk_out)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            oneshot_q    <= 1'b0;
            shadow_div_q <= NBITS'(DEFAULT_DIV);
            shadow_os_q  <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (w_load) begin
                oneshot_q <= w_load_os;
            end
            if (stop) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            state_q <= RUN;
                        end
                    end
                    RUN: begin
                        if (w_wrap) begin
                            if (oneshot_q) begin
                                done_q  <= 1'b1;
                                state_q <= IDLE;
                            end
                        end else if (w_xfer) begin
                            shadow_div_q <= cfg_div;
                            shadow_os_q  <= cfg_oneshot;
                            state_q      <= PEND;
                        end
                    end
                    PEND: begin
                        // The period that ends here still obeys the old mode.
                        if (w_wrap) begin
                            done_q  <= oneshot_q;
                            state_q <= oneshot_q ? IDLE : RUN;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

`ifdef CLKGEN_TICK_CNT_EN
    logic [NBITS-1:0] tick_cnt_q;

    assign tick_cnt = tick_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt_q <= '0;
        end else if (state_q == IDLE && start && !stop) begin
            tick_cnt_q <= '0;
        end else if (w_wrap && !stop && !(&tick_cnt_q)) begin
            tick_cnt_q <= tick_cnt_q + NBITS'(1);
        end
    end
`endif

endmodule : clk_div_sched

`default_nettype wire

// File: tb/tb_clk_div_sched.sv
// ============================================================================
// Module      : tb_clk_div_sched
// Description : Self-checking bench for clk_div_sched against a cycle-level
//               behavioural model; optional checks under CLKGEN_TICK_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clk_div_sched;

    localparam int NB = 16;

    logic          clk;
    logic          reset;
    logic          start;
    logic          stop;
    logic          cfg_valid;
    logic [NB-1:0] cfg_div;
    logic          cfg_oneshot;
    logic          cfg_ready;
    logic          tick;
    logic          clk_out;
    logic          busy;
    logic          done;
`ifdef CLKGEN_TICK_CNT_EN
    logic [NB-1:0] tick_cnt;
`endif

    clk_div_sched #(.NBITS(NB), .DEFAULT_DIV(5)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .cfg_valid   (cfg_valid),
        .cfg_div     (cfg_div),
        .cfg_oneshot (cfg_oneshot),
        .cfg_ready   (cfg_ready),
        .tick        (tick),
        .clk_out     (clk_out),
        .busy        (busy),
`ifdef CLKGEN_TICK_CNT_EN
        .done        (done),
        .tick_cnt    (tick_cnt)
`else
        .done        (done)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: "running" plus elapsed cycles in the current period.
    bit m_running, m_pending;
    int m_elapsed, m_period, m_sh_period;
    bit m_os, m_sh_os;
    bit m_tick, m_clk, m_done;
    int m_tcnt;

    function automatic int eff(input int d);
        return (d == 0) ? 1 : d;
    endfunction

    task automatic model_reset();
        m_running = 0; m_pending = 0; m_elapsed = 0; m_period = 5;
        m_sh_period = 5; m_os = 0; m_sh_os = 0;
        m_tick = 0; m_clk = 0; m_done = 0; m_tcnt = 0;
    endtask

    task automatic model_step(input bit r, input bit st, input bit sp,
                              input bit v, input int d, input bit o);
        bit xfer;
        bit period_end;
        bit old_os;
        xfer       = v && !m_pending;
        period_end = m_running && (m_elapsed + 1 == m_period);
        m_tick     = 0;
        m_done     = 0;
        if (r) begin
            model_reset();
        end else if (sp) begin
            if (m_pending) begin
                m_period = m_sh_period; m_os = m_sh_os;
            end else if (xfer) begin
                m_period = eff(d); m_os = o;
            end
            m_running = 0; m_pending = 0; m_elapsed = 0;
        end else if (!m_running) begin
            if (xfer) begin
                m_period = eff(d); m_os = o;
            end
            if (st) begin
                m_running = 1; m_elapsed = 0; m_tcnt = 0;
            end
        end else if (period_end) begin
            old_os    = m_os;
            m_tick    = 1;
            m_clk     = !m_clk;
            m_elapsed = 0;
            if (m_tcnt < 65535) m_tcnt++;
            if (m_pending) begin
                m_period = m_sh_period; m_os = m_sh_os;
            end else if (xfer) begin
                m_period = eff(d); m_os = o;
            end
            m_pending = 0;
            if (old_os) begin
                m_done = 1; m_running = 0;
            end
        end else begin
            m_elapsed++;
            if (xfer) begin
                m_sh_period = eff(d); m_sh_os = o; m_pending = 1;
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Drive one cycle, advance the model, then compare just after the edge.
    task automatic cycle(input bit r, input bit st, input bit sp,
                         input bit v, input int d, input bit o);
        reset = r; start = st; stop = sp; cfg_valid = v;
        cfg_div = NB'(d); cfg_oneshot = o;
        model_step(r, st, sp, v, d, o);
        @(posedge clk);
        #1;
        chk("outputs{tick,clk_out,done,busy,ready}",
            {27'd0, tick, clk_out, done, busy, cfg_ready},
            {27'd0, m_tick, m_clk, m_done, m_running, !m_pending});
`ifdef CLKGEN_TICK_CNT_EN
        chk("tick_cnt", int'(tick_cnt), m_tcnt);
`endif
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1; start = 0; stop = 0; cfg_valid = 0; cfg_div = '0; cfg_oneshot = 0;
        model_reset();
        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        chk("reset_busy", busy, 0);
        chk("reset_ready", cfg_ready, 1);
        chk("reset_clk_out", clk_out, 0);

        // Default divisor 5: ticks on cycles 5, 10, 15 after start.
        cycle(0, 1, 0, 0, 0, 0);
        chk("run_busy", busy, 1);
        for (int k = 1; k <= 15; k++) begin
            cycle(0, 0, 0, 0, 0, 0);
            if (k == 4)  chk("no_tick_c4", tick, 0);
            if (k == 5)  begin chk("tick_c5", tick, 1); chk("clk_out_c5", clk_out, 1); end
            if (k == 10) begin chk("tick_c10", tick, 1); chk("clk_out_c10", clk_out, 0); end
            if (k == 15) chk("tick_c15", tick, 1);
        end

        // One-shot with N=3.
        cycle(0, 0, 1, 0, 0, 0);
        cycle(0, 0, 0, 1, 3, 1);
        cycle(0, 1, 0, 0, 0, 0);
        idle_n(2);
        chk("os_no_tick_c2", tick, 0);
        cycle(0, 0, 0, 0, 0, 0);
        chk("os_tick", tick, 1);
        chk("os_done", done, 1);
        chk("os_idle", busy, 0);
        idle_n(4);
        chk("os_no_retick", tick, 0);

        // N=8, new divisor 2 offered at count 3.
        cycle(0, 0, 0, 1, 8, 0);
        cycle(0, 1, 0, 0, 0, 0);
        idle_n(3);
        cycle(0, 0, 0, 1, 2, 0);
        chk("pend_ready0", cfg_ready, 0);
        idle_n(3);
        chk("pend_ready0_c4", cfg_ready, 0);
        cycle(0, 0, 0, 0, 0, 0);
        chk("old_boundary_tick", tick, 1);
        chk("ready_back", cfg_ready, 1);
        cycle(0, 0, 0, 0, 0, 0);
        chk("n2_gap", tick, 0);
        cycle(0, 0, 0, 0, 0, 0);
        chk("n2_tick", tick, 1);

        // cfg_div=0 behaves as 1; then stop+start together, stop on a wrap.
        cycle(0, 0, 1, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 0);
        cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        chk("n1_tick_a", tick, 1);
        cycle(0, 0, 0, 0, 0, 0);
        chk("n1_tick_b", tick, 1);
        cycle(0, 1, 1, 0, 0, 0);
        chk("stop_wins_busy", busy, 0);
        chk("stop_wrap_tick", tick, 0);
        chk("stop_wrap_done", done, 0);
        cycle(0, 1, 0, 0, 0, 0);
        idle_n(2);
        cycle(1, 0, 0, 0, 0, 0);
        chk("mid_reset_busy", busy, 0);
        chk("mid_reset_clk_out", clk_out, 0);

`ifdef CLKGEN_TICK_CNT_EN
        cycle(0, 0, 0, 1, 2, 0);
        cycle(0, 1, 0, 0, 0, 0);
        idle_n(8);
        chk("tick_cnt_4", int'(tick_cnt), 4);
        cycle(0, 0, 1, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0);
        chk("tick_cnt_restart", int'(tick_cnt), 0);
`endif

        // Randomized traffic, continuously compared against the model.
        for (int i = 0; i < 4000; i++) begin
            cycle(($urandom_range(0, 299) == 0),
                  ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 5) == 0),
                  int'($urandom_range(0, 9)),
                  ($urandom_range(0, 3) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_clk_div_sched

`default_nettype wire
